// File: rtl/i2c_slave_responder.sv
`default_nettype none
// ============================================================================
// Module   : i2c_slave_responder
// Brief    : I2C target. Oversamples SCL/SDA, detects START/STOP, ACKs a
//            7-bit address, strobes out written bytes and requests bytes
//            to return on reads. SDA is open-drain (pull-low enable only).
// Revision : 1.0 - initial release
// ============================================================================
module i2c_slave_responder #(
    parameter logic [6:0] SLAVE_ADDRESS = 7'h68,
    parameter int         SYNC_STAGES   = 2
) (
    input  logic       pclk,
    input  logic       areset,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] wr_data,
    output logic       wr_valid,
    output logic       rd_req,
    input  logic [7:0] rd_data,
    output logic       addr_hit,
    output logic       busy
);

    // Depth below 2 is not a safe synchronizer; clamp it.
    localparam int c_SYNC_STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_ADDR      = 3'd1;
    localparam logic [2:0] c_ADDR_ACK  = 3'd2;
    localparam logic [2:0] c_WR_DATA   = 3'd3;
    localparam logic [2:0] c_WR_ACK    = 3'd4;
    localparam logic [2:0] c_RD_DATA   = 3'd5;
    localparam logic [2:0] c_RD_ACK    = 3'd6;
    localparam logic [2:0] c_WAIT_STOP = 3'd7;

    logic [c_SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
    logic       r_p_scl, r_p_sda;
    logic       w_s_scl, w_s_sda;
    logic       w_rise, w_fall, w_start, w_stop;

    logic [2:0] r_state, w_next_state;
    logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
    logic       r_bit_done, w_bit_done_nxt;
    logic [7:0] r_shift, w_shift_nxt;
    logic       r_rw, w_rw_nxt;
    logic       r_nack, w_nack_nxt;
    logic       r_sda_oe, w_sda_oe_nxt;
    logic [7:0] r_wr_data, w_wr_data_nxt;
    logic       r_wr_valid, w_wr_valid_nxt;
    logic       r_addr_hit, w_addr_hit_nxt;
    logic       w_rd_req;
    logic       w_match;

    // Input synchronizers and previous-sample registers; reset to idle bus.
    always_ff @(posedge pclk) begin
        if (areset) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_p_scl    <= 1'b1;
            r_p_sda    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[c_SYNC_STAGES-2:0], scl_i};
            r_sda_sync <= {r_sda_sync[c_SYNC_STAGES-2:0], sda_i};
            r_p_scl    <= w_s_scl;
            r_p_sda    <= w_s_sda;
        end
    end

    assign w_s_scl = r_scl_sync[c_SYNC_STAGES-1];
    assign w_s_sda = r_sda_sync[c_SYNC_STAGES-1];
    assign w_rise  = !r_p_scl &  w_s_scl;
    assign w_fall  =  r_p_scl & !w_s_scl;
    assign w_start =  r_p_scl &  w_s_scl &  r_p_sda & !w_s_sda;
    assign w_stop  =  r_p_scl &  w_s_scl & !r_p_sda &  w_s_sda;
    assign w_match = (r_shift[7:1] == SLAVE_ADDRESS);

    // State register.
    always_ff @(posedge pclk) begin
        if (areset) r_state <= c_IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state logic; bus conditions override every other transition.
    always_comb begin
        w_next_state = r_state;
        if (w_start) begin
            w_next_state = c_ADDR;
        end else if (w_stop) begin
            w_next_state = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE:      w_next_state = c_IDLE;
                c_ADDR:      if (w_fall && r_bit_done) w_next_state = w_match ? c_ADDR_ACK : c_WAIT_STOP;
                c_ADDR_ACK:  if (w_fall) w_next_state = r_rw ? c_RD_DATA : c_WR_DATA;
                c_WR_DATA:   if (w_fall && r_bit_done) w_next_state = c_WR_ACK;
                c_WR_ACK:    if (w_fall) w_next_state = c_WR_DATA;
                c_RD_DATA:   if (w_fall && r_bit_done) w_next_state = c_RD_ACK;
                c_RD_ACK:    if (w_fall) w_next_state = r_nack ? c_WAIT_STOP : c_RD_DATA;
                c_WAIT_STOP: w_next_state = c_WAIT_STOP;
                default:     w_next_state = c_IDLE;
            endcase
        end
    end

    // Output/datapath next values; sda_oe only moves on SCL fall, START or STOP.
    always_comb begin
        w_bit_cnt_nxt  = r_bit_cnt;
        w_bit_done_nxt = r_bit_done;
        w_shift_nxt    = r_shift;
        w_rw_nxt       = r_rw;
        w_nack_nxt     = r_nack;
        w_sda_oe_nxt   = r_sda_oe;
        w_wr_data_nxt  = r_wr_data;
        w_wr_valid_nxt = 1'b0;
        w_addr_hit_nxt = 1'b0;
        w_rd_req       = 1'b0;
        if (w_start) begin
            w_sda_oe_nxt   = 1'b0;
            w_bit_cnt_nxt  = 3'd0;
            w_bit_done_nxt = 1'b0;
        end else if (w_stop) begin
            w_sda_oe_nxt = 1'b0;
        end else begin
            case (r_state)
                c_ADDR, c_WR_DATA: begin
                    if (w_rise && !r_bit_done) begin
                        w_shift_nxt    = {r_shift[6:0], w_s_sda};
                        w_bit_cnt_nxt  = r_bit_cnt + 3'd1;
                        w_bit_done_nxt = (r_bit_cnt == 3'd7);
                    end else if (w_fall && r_bit_done) begin
                        if (r_state == c_WR_DATA) begin
                            w_wr_data_nxt  = r_shift;
                            w_wr_valid_nxt = 1'b1;
                            w_sda_oe_nxt   = 1'b1;
                        end else if (w_match) begin
                            w_sda_oe_nxt   = 1'b1;
                            w_addr_hit_nxt = 1'b1;
                            w_rw_nxt       = r_shift[0];
                        end else begin
                            w_sda_oe_nxt = 1'b0;
                        end
                    end
                end
                c_ADDR_ACK, c_WR_ACK: begin
                    if (w_fall) begin
                        w_bit_cnt_nxt  = 3'd0;
                        w_bit_done_nxt = 1'b0;
                        if (r_state == c_ADDR_ACK && r_rw) begin
                            w_rd_req     = 1'b1;
                            w_shift_nxt  = rd_data;
                            w_sda_oe_nxt = ~rd_data[7];
                        end else begin
                            w_sda_oe_nxt = 1'b0;
                        end
                    end
                end
                c_RD_DATA: begin
                    if (w_rise && !r_bit_done) begin
                        w_bit_cnt_nxt  = r_bit_cnt + 3'd1;
                        w_bit_done_nxt = (r_bit_cnt == 3'd7);
                    end else if (w_fall) begin
                        if (r_bit_done) begin
                            w_sda_oe_nxt = 1'b0;
                        end else begin
                            w_shift_nxt  = {r_shift[6:0], 1'b0};
                            w_sda_oe_nxt = ~r_shift[6];
                        end
                    end
                end
                c_RD_ACK: begin
                    if (w_rise) begin
                        w_nack_nxt = w_s_sda;
                    end else if (w_fall && !r_nack) begin
                        w_rd_req       = 1'b1;
                        w_shift_nxt    = rd_data;
                        w_sda_oe_nxt   = ~rd_data[7];
                        w_bit_cnt_nxt  = 3'd0;
                        w_bit_done_nxt = 1'b0;
                    end
                end
                c_WAIT_STOP: w_sda_oe_nxt = 1'b0;
                default:     w_sda_oe_nxt = 1'b0;
            endcase
        end
    end

    // Datapath and registered pulse outputs.
    always_ff @(posedge pclk) begin
        if (areset) begin
            r_bit_cnt  <= 3'd0;
            r_bit_done <= 1'b0;
            r_shift    <= 8'h00;
            r_rw       <= 1'b0;
            r_nack     <= 1'b0;
            r_sda_oe   <= 1'b0;
            r_wr_data  <= 8'h00;
            r_wr_valid <= 1'b0;
            r_addr_hit <= 1'b0;
        end else begin
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_bit_done <= w_bit_done_nxt;
            r_shift    <= w_shift_nxt;
            r_rw       <= w_rw_nxt;
            r_nack     <= w_nack_nxt;
            r_sda_oe   <= w_sda_oe_nxt;
            r_wr_data  <= w_wr_data_nxt;
            r_wr_valid <= w_wr_valid_nxt;
            r_addr_hit <= w_addr_hit_nxt;
        end
    end

    assign sda_oe   = r_sda_oe;
    assign wr_data  = r_wr_data;
    assign wr_valid = r_wr_valid;
    assign addr_hit = r_addr_hit;
    assign rd_req   = w_rd_req;
    assign busy     = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_slave_responder
// Brief    : Directed bench for i2c_slave_responder with a simple master
//            model on a wired-AND SDA line.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_slave_responder;

    localparam int c_Q = 8;  // pclk cycles per quarter SCL period

    logic       pclk = 1'b0;
    logic       areset;
    logic       scl_m, sda_m;
    logic       scl_i, sda_i;
    logic       sda_oe;
    logic [7:0] wr_data;
    logic       wr_valid, rd_req, addr_hit, busy;
    logic [7:0] rd_data;

    int n_total = 0;
    int n_bad   = 0;
    int n_hit = 0, n_wr = 0, n_rd = 0, n_excl = 0;
    int b_hit, b_wr, b_rd;
    logic [7:0] wr_log [64];
    logic [7:0] rd_tbl [4];
    logic       ack;
    logic [7:0] rx;

    always #5 pclk = ~pclk;

    assign scl_i   = scl_m;
    assign sda_i   = sda_m & ~sda_oe;
    assign rd_data = rd_tbl[(n_rd - b_rd) & 3];

    i2c_slave_responder #(.SLAVE_ADDRESS(7'h68), .SYNC_STAGES(2)) u_dut (
        .pclk(pclk), .areset(areset), .scl_i(scl_i), .sda_i(sda_i),
        .sda_oe(sda_oe), .wr_data(wr_data), .wr_valid(wr_valid),
        .rd_req(rd_req), .rd_data(rd_data), .addr_hit(addr_hit), .busy(busy)
    );

    // Pulse monitor.
    always @(posedge pclk) begin
        if (areset !== 1'b1) begin
            if (addr_hit === 1'b1) n_hit <= n_hit + 1;
            if (wr_valid === 1'b1) begin
                wr_log[n_wr & 63] <= wr_data;
                n_wr <= n_wr + 1;
            end
            if (rd_req === 1'b1) n_rd <= n_rd + 1;
            if ((32'(addr_hit === 1'b1) + 32'(wr_valid === 1'b1) + 32'(rd_req === 1'b1)) > 1)
                n_excl <= n_excl + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wq(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic mark();
        b_hit = n_hit; b_wr = n_wr; b_rd = n_rd;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; scl_m = 1'b1; wq(c_Q);
        sda_m = 1'b0; wq(c_Q);
        scl_m = 1'b0; wq(c_Q);
    endtask

    task automatic i2c_rep_start();
        sda_m = 1'b1; wq(c_Q);
        scl_m = 1'b1; wq(c_Q);
        sda_m = 1'b0; wq(c_Q);
        scl_m = 1'b0; wq(c_Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wq(c_Q);
        scl_m = 1'b1; wq(c_Q);
        sda_m = 1'b1; wq(c_Q);
    endtask

    // One SCL clock; returns the resolved SDA level sampled mid-high.
    task automatic i2c_bit(input logic b, input logic glitch, output logic seen);
        if (glitch) begin
            for (int k = 0; k < 4; k++) begin
                sda_m = ~sda_m; wq(1);
            end
        end
        sda_m = b;     wq(c_Q);
        scl_m = 1'b1;  wq(c_Q);
        seen  = sda_i; wq(c_Q);
        scl_m = 1'b0;  wq(c_Q);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic glitch, output logic ack_o);
        logic s;
        for (int i = 7; i >= 0; i--) i2c_bit(d[i], glitch && (i == 5), s);
        i2c_bit(1'b1, 1'b0, ack_o);
    endtask

    task automatic recv_byte(input logic ack_i, output logic [7:0] d);
        logic s;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            i2c_bit(1'b1, 1'b0, s);
            d = {d[6:0], s};
        end
        i2c_bit(ack_i, 1'b0, s);
    endtask

    initial begin
        logic s;
        scl_m = 1'b1; sda_m = 1'b1; areset = 1'b1;
        b_hit = 0; b_wr = 0; b_rd = 0;
        for (int i = 0; i < 4; i++) rd_tbl[i] = 8'h00;
        wq(4);
        chk("rst_sda_oe", 32'(sda_oe), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_pulses", {29'd0, wr_valid, rd_req, addr_hit}, 0);
        areset = 1'b0; wq(8);

        // Write 0x68/W, 0xA5, 0x3C.
        mark();
        i2c_start();
        send_byte(8'hD0, 1'b0, ack); chk("wr_addr_ack", 32'(ack), 0);
        send_byte(8'hA5, 1'b0, ack); chk("wr_d0_ack", 32'(ack), 0);
        send_byte(8'h3C, 1'b0, ack); chk("wr_d1_ack", 32'(ack), 0);
        chk("wr_busy", 32'(busy), 1);
        i2c_stop(); wq(8);
        chk("wr_idle", 32'(busy), 0);
        chk("wr_hits", 32'(n_hit - b_hit), 1);
        chk("wr_count", 32'(n_wr - b_wr), 2);
        chk("wr_b0", 32'(wr_log[b_wr & 63]), 32'hA5);
        chk("wr_b1", 32'(wr_log[(b_wr + 1) & 63]), 32'h3C);
        chk("wr_no_rd", 32'(n_rd - b_rd), 0);

        // Read 0x68/R: 0x96 (ACK), 0x5A (NACK).
        mark();
        rd_tbl[0] = 8'h96; rd_tbl[1] = 8'h5A;
        i2c_start();
        send_byte(8'hD1, 1'b0, ack); chk("rd_addr_ack", 32'(ack), 0);
        recv_byte(1'b0, rx); chk("rd_b0", 32'(rx), 32'h96);
        recv_byte(1'b1, rx); chk("rd_b1", 32'(rx), 32'h5A);
        wq(c_Q);
        chk("rd_release", 32'(sda_oe), 0);
        chk("rd_wait_stop", 32'(busy), 1);
        chk("rd_reqs", 32'(n_rd - b_rd), 2);
        i2c_stop(); wq(8);
        chk("rd_idle", 32'(busy), 0);

        // Address mismatch 0x27/W.
        mark();
        i2c_start();
        send_byte(8'h4E, 1'b0, ack); chk("nm_nack", 32'(ack), 1);
        send_byte(8'h55, 1'b0, ack); chk("nm_data_nack", 32'(ack), 1);
        chk("nm_busy", 32'(busy), 1);
        chk("nm_hits", 32'(n_hit - b_hit), 0);
        chk("nm_wr", 32'(n_wr - b_wr), 0);
        i2c_stop(); wq(8);
        chk("nm_idle", 32'(busy), 0);

        // Write 0x11, repeated START, read 0xC3 with NACK.
        mark();
        rd_tbl[0] = 8'hC3;
        i2c_start();
        send_byte(8'hD0, 1'b0, ack); chk("rs_waddr_ack", 32'(ack), 0);
        send_byte(8'h11, 1'b0, ack); chk("rs_wdata_ack", 32'(ack), 0);
        i2c_rep_start();
        send_byte(8'hD1, 1'b0, ack); chk("rs_raddr_ack", 32'(ack), 0);
        recv_byte(1'b1, rx); chk("rs_rd", 32'(rx), 32'hC3);
        i2c_stop(); wq(8);
        chk("rs_wr_count", 32'(n_wr - b_wr), 1);
        chk("rs_wr_b0", 32'(wr_log[b_wr & 63]), 32'h11);
        chk("rs_hits", 32'(n_hit - b_hit), 2);
        chk("rs_reqs", 32'(n_rd - b_rd), 1);

        // Reset while ACKing a written byte, then a clean write of 0xFF.
        i2c_start();
        send_byte(8'hD0, 1'b0, ack);
        for (int i = 7; i >= 0; i--) i2c_bit(1'b0, 1'b0, s);
        sda_m = 1'b1; wq(c_Q);
        chk("ar_ack_drive", 32'(sda_oe), 1);
        areset = 1'b1; wq(1);
        chk("ar_sda_oe", 32'(sda_oe), 0);
        chk("ar_busy", 32'(busy), 0);
        chk("ar_wr_data", 32'(wr_data), 0);
        areset = 1'b0; wq(2);
        scl_m = 1'b1; wq(c_Q);
        mark();
        i2c_start();
        send_byte(8'hD0, 1'b0, ack); chk("ar_addr_ack", 32'(ack), 0);
        send_byte(8'hFF, 1'b0, ack); chk("ar_data_ack", 32'(ack), 0);
        i2c_stop(); wq(8);
        chk("ar_wr_count", 32'(n_wr - b_wr), 1);
        chk("ar_wr_b0", 32'(wr_log[b_wr & 63]), 32'hFF);
        chk("ar_idle", 32'(busy), 0);

        // SDA glitching while SCL is low must not look like START/STOP.
        mark();
        i2c_start();
        send_byte(8'hD0, 1'b0, ack);
        send_byte(8'h5A, 1'b1, ack); chk("gl_ack", 32'(ack), 0);
        chk("gl_busy", 32'(busy), 1);
        i2c_stop(); wq(8);
        chk("gl_hits", 32'(n_hit - b_hit), 1);
        chk("gl_wr_count", 32'(n_wr - b_wr), 1);
        chk("gl_wr_b0", 32'(wr_log[b_wr & 63]), 32'h5A);

        chk("pulse_exclusive", 32'(n_excl), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
